// File: rtl/instr_sequencer.sv
// Instruction fetch/execute sequencer: fetches a word, presents it for one
// execute cycle, advances the PC. Optional build macro: SEQ_HALT_ON_OVFL_EN.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        pc_src,
  input  logic [15:0] imm_16,
  input  logic        overflow,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [15:0] retired_count
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | request word at pc, wait for imem_ack
  // EXEC  | instr valid for one cycle, next pc computed
  // HALT  | stopped; only reset leaves
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;

  logic [31:0] pc_inc;
  logic [31:0] branch_off;
  logic [31:0] pc_next;

  assign pc_inc     = pc_q + 32'd4;
  assign branch_off = {{14{imm_16[15]}}, imm_16, 2'b00};
  assign pc_next    = pc_src ? (pc_inc + branch_off) : pc_inc;

`ifndef SEQ_HALT_ON_OVFL_EN
  // Port kept for a uniform pinout; ignored in this build.
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = (imem_rdata[31:26] == HALT_OPCODE) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        retired_d = retired_q + 16'd1;
`ifdef SEQ_HALT_ON_OVFL_EN
        // Faulting instruction keeps its own address in pc.
        if (overflow) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_next;
          state_d = S_FETCH;
        end
`else
        pc_d    = pc_next;
        state_d = S_FETCH;
`endif
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == S_EXEC);
  assign busy          = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted        = (state_q == S_HALT);
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: transaction-level model compared
// every cycle, plus directed literal checks.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pc_src;
  logic [15:0] imm_16;
  logic        overflow;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic [15:0] retired_count;

  int tests = 0;
  int fails = 0;

`ifdef SEQ_HALT_ON_OVFL_EN
  localparam bit OVFL_EN = 1'b1;
`else
  localparam bit OVFL_EN = 1'b0;
`endif

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc_src(pc_src), .imm_16(imm_16), .overflow(overflow),
    .pc(pc), .busy(busy), .halted(halted), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the sequencer is doing, in plain numbers.
  localparam int PH_WAITING  = 0;
  localparam int PH_FETCHING = 1;
  localparam int PH_RUNNING  = 2;
  localparam int PH_STOPPED  = 3;
  localparam longint TWO32   = 64'h1_0000_0000;

  int          m_phase = PH_WAITING;
  longint      m_pc    = 0;
  int          m_ret   = 0;
  logic [31:0] m_instr = 32'h0;

  always @(posedge clk or posedge reset) begin
    longint step;
    if (reset) begin
      m_phase = PH_WAITING;
      m_pc    = 0;
      m_ret   = 0;
      m_instr = 32'h0;
    end else if (m_phase == PH_WAITING) begin
      if (start === 1'b1) begin
        m_pc    = 0;
        m_phase = PH_FETCHING;
      end
    end else if (m_phase == PH_FETCHING) begin
      if (imem_ack === 1'b1) begin
        m_instr = imem_rdata;
        m_phase = (int'(imem_rdata >> 26) == 63) ? PH_STOPPED : PH_RUNNING;
      end
    end else if (m_phase == PH_RUNNING) begin
      m_ret = (m_ret + 1) % 65536;
      if (OVFL_EN && overflow === 1'b1) begin
        m_phase = PH_STOPPED;
      end else begin
        step    = pc_src ? (4 + 4 * longint'($signed(imm_16))) : 4;
        m_pc    = (m_pc + step + TWO32) % TWO32;
        m_phase = PH_FETCHING;
      end
    end
  end

  int req_cycles  = 0;
  int exec_cycles = 0;

  always @(negedge clk) begin
    check("cyc_imem_req",    {31'd0, imem_req},    {31'd0, m_phase == PH_FETCHING});
    check("cyc_instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == PH_RUNNING});
    check("cyc_busy",        {31'd0, busy},
          {31'd0, (m_phase == PH_FETCHING) || (m_phase == PH_RUNNING)});
    check("cyc_halted",      {31'd0, halted},      {31'd0, m_phase == PH_STOPPED});
    check("cyc_pc",          pc,                   m_pc[31:0]);
    check("cyc_imem_addr",   imem_addr,            m_pc[31:0]);
    check("cyc_instr",       instr,                m_instr);
    check("cyc_retired",     {16'd0, retired_count}, m_ret[31:0]);
    if (imem_req)    req_cycles++;
    if (instr_valid) exec_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered while in FETCH; leaves after EXEC (or after a halt fetch).
  task automatic fetch_exec(input logic [31:0] word, input int waits,
                            input logic psrc, input logic [15:0] imm, input logic ovf);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    pc_src   = psrc;
    imm_16   = imm;
    overflow = ovf;
    tick();
    pc_src   = 1'b0;
    imm_16   = 16'h0;
    overflow = 1'b0;
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  initial begin
    reset = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    pc_src = 1'b0; imm_16 = 16'h0; overflow = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", {16'd0, retired_count}, 32'd0);
    check("rst_instr", instr, 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    // ack while idle must be ignored
    imem_ack = 1'b1; imem_rdata = HALT;
    tick(); tick();
    imem_ack = 1'b0;
    check("idle_ack_halted", {31'd0, halted}, 32'd0);
    check("idle_ack_instr", instr, 32'h0);

    do_start();
    check("start_req", {31'd0, imem_req}, 32'd1);
    check("start_addr", imem_addr, 32'h0);
    req_cycles = 0; exec_cycles = 0;
    fetch_exec(NOP, 0, 1'b0, 16'h0, 1'b0);
    check("first_pc", pc, 32'h4);
    check("first_retired", {16'd0, retired_count}, 32'd1);
    check("first_addr", imem_addr, 32'h4);
    check("first_exec_cycles", exec_cycles, 32'd1);
    check("first_instr", instr, NOP);

    req_cycles = 0; exec_cycles = 0;
    fetch_exec(NOP, 3, 1'b0, 16'h0, 1'b0);
    check("wait3_req_cycles", req_cycles, 32'd4);
    check("wait3_exec_cycles", exec_cycles, 32'd1);
    check("wait3_pc", pc, 32'h8);

    fetch_exec(NOP, 1, 1'b0, 16'h0, 1'b0);
    fetch_exec(NOP, 0, 1'b0, 16'h0, 1'b0);
    check("pre_branch_pc", pc, 32'h10);
    fetch_exec(32'h1000_0003, 0, 1'b1, 16'h0003, 1'b0);
    check("branch_fwd_pc", pc, 32'h20);
    fetch_exec(32'h1000_FFFB, 2, 1'b1, 16'hFFFB, 1'b0);
    check("branch_back_pc", pc, 32'h10);
    fetch_exec(32'h1000_FFFE, 0, 1'b1, 16'hFFFE, 1'b0);
    check("branch_neg_pc", pc, 32'h0C);
    fetch_exec(32'h1000_000C, 0, 1'b1, 16'h000C, 1'b0);
    check("to_40_pc", pc, 32'h40);

    // start is ignored in FETCH
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_exec(NOP, 0, 1'b0, 16'h0, 1'b1);
    check("ovf_retired", {16'd0, retired_count}, 32'd9);
`ifdef SEQ_HALT_ON_OVFL_EN
    check("ovf_halted", {31'd0, halted}, 32'd1);
    check("ovf_pc", pc, 32'h40);
`else
    check("ovf_halted", {31'd0, halted}, 32'd0);
    check("ovf_pc", pc, 32'h44);
    check("ovf_fetching", {31'd0, imem_req}, 32'd1);
`endif

    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    do_start();
    fetch_exec(NOP, 0, 1'b0, 16'h0, 1'b0);
    fetch_exec(NOP, 1, 1'b0, 16'h0, 1'b0);
    check("pre_halt_pc", pc, 32'h8);
    exec_cycles = 0;
    fetch_exec(HALT, 1, 1'b1, 16'h0005, 1'b0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_pc", pc, 32'h8);
    check("halt_retired", {16'd0, retired_count}, 32'd2);
    check("halt_no_valid", exec_cycles, 32'd0);
    do_start();
    tick();
    check("halt_start_ignored", {31'd0, halted}, 32'd1);
    check("halt_start_pc", pc, 32'h8);

    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    do_start();
    imem_ack = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    tick();
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = NOP;
    tick(); tick();
    imem_ack = 1'b0;
    tick();
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_instr", instr, 32'h0);
    check("postrst_retired", {16'd0, retired_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after start.
REQ-002 Parameter HALT_OPCODE, default 6'h3F, opcode field (bits 31:26) that stops sequencing.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse, begins fetching from RESET_PC.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  32  fetch address (current PC).
REQ-008 imem_ack  input  1  memory reports imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr  output  32  registered instruction driven to the processor Instr input.
REQ-011 instr_valid  output  1  instr is executing this cycle.
REQ-012 pc_src  input  1  processor PCSrc (branch taken), sampled during EXEC.
REQ-013 imm_16  input  16  processor immediate field, sampled during EXEC.
REQ-014 overflow  input  1  processor ALU overflow, sampled during EXEC.
REQ-015 pc  output  32  current program counter.
REQ-016 busy  output  1  high in FETCH or EXEC.
REQ-017 halted  output  1  high in HALT.
REQ-018 retired_count  output  16  number of instructions executed.

Function
REQ-019 The FSM SHALL have four states: IDLE, FETCH, EXEC and HALT.
REQ-020 In IDLE, start=1 SHALL load pc with RESET_PC and move to FETCH on the next edge; with start=0, IDLE SHALL hold.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the state SHALL hold until imem_ack=1.
REQ-022 On imem_ack=1 in FETCH, imem_rdata SHALL be registered into instr. The next state SHALL be HALT if imem_rdata[31:26]==HALT_OPCODE, else EXEC.
REQ-023 In EXEC, instr_valid SHALL be 1 for exactly one cycle and imem_req SHALL be 0.
REQ-024 At the end of EXEC, pc SHALL become pc+4+(sign_extend(imm_16)<<2) if pc_src=1, else pc+4, modulo 2^32.
REQ-025 At the end of EXEC, retired_count SHALL increment, wrapping 16'hFFFF to 0, and the state SHALL return to FETCH.
REQ-026 The minimum latency per instruction SHALL be 2 cycles (ack in the first FETCH cycle); each extra wait cycle adds one.
REQ-027 A halt instruction SHALL NOT assert instr_valid, SHALL NOT increment retired_count, and SHALL leave pc at its own address.
REQ-028 HALT SHALL be exited only by reset; start SHALL be ignored in FETCH, EXEC and HALT.
REQ-029 imem_ack SHALL be ignored outside FETCH.
REQ-030 instr SHALL hold its last value outside EXEC.
REQ-031 busy SHALL be 1 exactly in FETCH and EXEC; halted SHALL be 1 exactly in HALT.

Reset
REQ-032 Assertion of reset SHALL immediately, without waiting for clk, force state=IDLE, pc=RESET_PC, instr=0, retired_count=0, and imem_req, instr_valid, busy and halted to 0.
REQ-033 Reset during FETCH SHALL abandon the request; a later imem_ack SHALL be ignored.
REQ-034 After reset deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-035 With SEQ_HALT_ON_OVFL_EN defined, overflow=1 in EXEC SHALL:
- move the FSM to HALT instead of FETCH;
- increment retired_count;
- leave pc holding the faulting instruction's address.
REQ-036 Without SEQ_HALT_ON_OVFL_EN, overflow SHALL be ignored and the port SHALL remain present.

Verification
REQ-037 Reset, start, ack on the first FETCH cycle, rdata=32'h0000_0020, pc_src=0 -> imem_addr=0, instr_valid one cycle later, then pc=4, retired_count=1, imem_addr=4.
REQ-038 Ack delayed 3 cycles -> imem_req held with imem_addr stable for 4 cycles, then one EXEC cycle; 5 cycles total per instruction.
REQ-039 Branch at pc=32'h10 with pc_src=1: imm_16=16'h0003 -> next pc=32'h20; imm_16=16'hFFFE -> next pc=32'h0C.
REQ-040 rdata=32'hFC00_0000 at pc=8 -> halted=1, busy=0, pc=8, retired_count unchanged, instr_valid never asserts; a later start is ignored.
REQ-041 Reset asserted mid-FETCH, asynchronous to clk -> imem_req=0 in the same cycle, pc=0, state IDLE; ack after reset has no effect.
REQ-042 SEQ_HALT_ON_OVFL_EN defined, overflow=1 in EXEC at pc=32'h40 -> halted=1, pc=32'h40, retired_count incremented; with the macro undefined -> pc=32'h44 and fetching continues.
